i2c_reg_seq_init: RTL and testbench
===================================

// Module: i2c_reg_seq_init
// PURPOSE
//  Parametrised I2C register-table sequencer for HDMI transmitter bring-up (ADV7513-class, dev 0x72).
//  - Walks an external {reg,data} table of NUM_REGS entries through i2c_controller.
//  - Retries NACKed writes up to MAX_RETRY times, with timeout and a retry back-off.
//  - Re-runs the whole table on a hot-plug interrupt.
//  - Replaces the fixed 31-entry init loop clocked off a 100 Hz derived clock; runs directly on clk_ref.
// PARAMETERS
//  NUM_REGS    31      table entries; transfers per pass, index 0..NUM_REGS-1
//  IDX_W       5       tbl_idx width; must satisfy 2**IDX_W >= NUM_REGS
//  DEV_ADDR    8'h72   8-bit write address driven on i2c_dev_addr
//  MAX_RETRY   7       NACK/timeout retries per entry before FAIL; 0..15
//  BACKOFF     2000    clk_ref cycles waited before each retry
//  TIMEOUT     200000  clk_ref cycles allowed for ready to return after acceptance
//  AUTO_START  1       1: start a pass automatically when reset is released
// PORTS
//  clk_ref       in   1      reference clock (50 MHz)
//  reset         in   1      asynchronous, active-high reset
//  go            in   1      1-cycle pulse: start a pass; ignored while busy
//  hdmi_tx_int   in   1      transmitter interrupt, active low; requests a re-init
//  tbl_idx       out  IDX_W  current table index
//  tbl_data      in   16     {reg[15:8],data[7:0]}; combinational function of tbl_idx
//  i2c_start     out  1      transfer request to i2c_controller
//  i2c_dev_addr  out  8      constant DEV_ADDR
//  i2c_reg_data  out  16     latched table word for the current transfer
//  i2c_ready     in   1      controller idle / transfer complete
//  i2c_ack       in   1      1 = slave ACKed the last transfer; valid when i2c_ready is high
//  busy          out  1      pass in progress
//  done          out  1      last pass completed with all entries ACKed
//  error         out  1      last pass aborted after retries were exhausted
//  retry_cnt     out  4      retries used on the current entry
//  state_out     out  3      FSM state encoding, for LED debug
// BEHAVIOUR
//  - Reset values: state IDLE; tbl_idx=0; i2c_start=0; i2c_reg_data=0.
//    Also at reset: busy=0, done=0, error=0, retry_cnt=0, internal counters 0.
//  - Reset mid-pass aborts immediately. i2c_start drops asynchronously; the table is not resumed.
//  - States: IDLE=0, LOAD=1, REQ=2, WAIT=3, NEXT=4, BACKOFF=5, DONE=6, FAIL=7.
//  - IDLE -> LOAD when go=1, or on the first cycle after reset release if AUTO_START=1.
//    Entering a pass sets tbl_idx=0, done=0, error=0, busy=1.
//  - LOAD: i2c_reg_data <= tbl_data. The next state is REQ.
//  - REQ: i2c_start=1 and held while i2c_ready=1.
//    The first cycle with i2c_ready=0 counts as acceptance; i2c_start=0 in that same cycle, then WAIT.
//  - WAIT: the timeout counter runs.
//    If i2c_ready=1 and i2c_ack=1: go to NEXT.
//    If i2c_ready=1 and i2c_ack=0, or the counter reaches TIMEOUT: retry.
//    A retry goes to BACKOFF if retry_cnt < MAX_RETRY and increments retry_cnt; otherwise it goes to FAIL.
//  - BACKOFF: waits BACKOFF cycles, then goes to REQ. i2c_reg_data is unchanged.
//  - NEXT: retry_cnt <= 0.
//    If tbl_idx == NUM_REGS-1: go to DONE.
//    Otherwise tbl_idx <= tbl_idx+1 and go to LOAD. No wrap past NUM_REGS-1.
//  - DONE: done=1, busy=0.
//    hdmi_tx_int=0 (after debounce, see CONFIGURATION) starts a new pass: re-enter LOAD with tbl_idx=0.
//    go also starts a new pass.
//  - FAIL: error=1, busy=0. Only go or reset leaves FAIL; hdmi_tx_int is ignored.
//  - hdmi_tx_int is ignored during a pass. It is not latched.
//  - go and hdmi_tx_int together in DONE: a single pass starts.
//  - Latency per clean entry: LOAD(1) + REQ(>=1) + WAIT(controller time) + NEXT(1) cycles.
//  - Inputs hdmi_tx_int and go pass through a 2-flop synchroniser. Add 2 cycles of latency.
// CONFIGURATION
//  HPD_DEBOUNCE_EN defined:
//    - hdmi_tx_int must read 0 for 4096 consecutive clk_ref cycles before a re-init triggers.
//    - Any 1 in that window clears the counter.
//  HPD_DEBOUNCE_EN undefined:
//    - The first synchronised 0 in DONE triggers the re-init.
// TESTING
//  1 AUTO_START=1, NUM_REGS=4, model ACKs all -> 4 transfers, words 0..3 in order; done=1, error=0.
//  2 Entry 2 NACKed twice, then ACKed -> retry_cnt reaches 2 then clears; 3 transfers of entry 2.
//    Each retry is separated by >= BACKOFF cycles; done=1.
//  3 Entry 1 always NACKed, MAX_RETRY=3 -> 4 attempts, then FAIL; error=1, busy=0.
//    tbl_idx holds 1; a go pulse restarts at tbl_idx=0.
//  4 Controller never returns ready, TIMEOUT=100 -> timeout retry after 100 cycles in WAIT;
//    FAIL after MAX_RETRY+1 timeouts.
//  5 In DONE, pulse hdmi_tx_int low for 10 cycles -> re-init with the macro undefined.
//    With HPD_DEBOUNCE_EN defined there is no re-init; holding it low for 4096 cycles triggers the pass.
//  6 Assert reset while in WAIT on entry 2 -> all outputs at reset values at once.
//    AUTO_START=1: a pass restarts at entry 0 after release.

Source files
------------

// File: rtl/i2c_reg_seq_init.sv
// Register-table sequencer: walks a {reg,data} table through an I2C controller with NACK/timeout retry,
// back-off and hot-plug re-init. Optional macro HPD_DEBOUNCE_EN enables a 4096-cycle hdmi_tx_int debounce.
module i2c_reg_seq_init #(
    parameter int          NUM_REGS   = 31,
    parameter int          IDX_W      = 5,
    parameter logic [7:0]  DEV_ADDR   = 8'h72,
    parameter int          MAX_RETRY  = 7,
    parameter int          BACKOFF    = 2000,
    parameter int          TIMEOUT    = 200000,
    parameter int          AUTO_START = 1
) (
    input  logic             clk_ref,
    input  logic             reset,
    input  logic             go,
    input  logic             hdmi_tx_int,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_data,
    output logic             i2c_start,
    output logic [7:0]       i2c_dev_addr,
    output logic [15:0]      i2c_reg_data,
    input  logic             i2c_ready,
    input  logic             i2c_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [3:0]       retry_cnt,
    output logic [2:0]       state_out
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int BO_W  = $clog2(BACKOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT    = 3'd3,
        S_NEXT    = 3'd4,
        S_BACKOFF = 3'd5,
        S_DONE    = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_reg_data;
    logic             r_start;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [3:0]       r_retry;
    logic [TMO_W-1:0] r_tmo;
    logic [BO_W-1:0]  r_bo;
    logic             r_auto;
    logic             r_go_m, r_go_s;
    logic             r_int_m, r_int_s;
    logic             w_hpd_trig;
    logic             w_start_pass;
    logic             w_retry;

    // hdmi_tx_int idles high, so its synchroniser resets to the inactive level.
    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            r_go_m  <= 1'b0;
            r_go_s  <= 1'b0;
            r_int_m <= 1'b1;
            r_int_s <= 1'b1;
        end else begin
            r_go_m  <= go;
            r_go_s  <= r_go_m;
            r_int_m <= hdmi_tx_int;
            r_int_s <= r_int_m;
        end
    end

`ifdef HPD_DEBOUNCE_EN
    logic [12:0] r_db;

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            r_db <= 13'd0;
        end else if (r_int_s) begin
            r_db <= 13'd0;
        end else if (r_db != 13'd4096) begin
            r_db <= r_db + 13'd1;
        end
    end

    assign w_hpd_trig = (r_db == 13'd4096);
`else
    assign w_hpd_trig = ~r_int_s;
`endif

    always_comb begin
        w_start_pass = 1'b0;
        case (r_state)
            S_IDLE:  w_start_pass = r_go_s | r_auto;
            S_DONE:  w_start_pass = r_go_s | w_hpd_trig;
            S_FAIL:  w_start_pass = r_go_s;
            default: w_start_pass = 1'b0;
        endcase
    end

    assign w_retry = (i2c_ready & ~i2c_ack) | (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_reg_data <= 16'h0000;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_retry    <= 4'd0;
            r_tmo      <= '0;
            r_bo       <= '0;
            r_auto     <= (AUTO_START != 0);
        end else begin
            r_auto <= 1'b0;
            if (w_start_pass) begin
                r_state <= S_LOAD;
                r_idx   <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
                r_busy  <= 1'b1;
                r_retry <= 4'd0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_reg_data <= tbl_data;
                        r_start    <= 1'b1;
                        r_state    <= S_REQ;
                    end
                    S_REQ: begin
                        // The controller dropping ready is taken as acceptance of the request.
                        if (!i2c_ready) begin
                            r_start <= 1'b0;
                            r_tmo   <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (i2c_ready && i2c_ack) begin
                            r_state <= S_NEXT;
                        end else if (w_retry) begin
                            if (r_retry < 4'(MAX_RETRY)) begin
                                r_retry <= r_retry + 4'd1;
                                r_bo    <= '0;
                                r_state <= S_BACKOFF;
                            end else begin
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FAIL;
                            end
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    S_BACKOFF: begin
                        if (r_bo == BO_W'(BACKOFF - 1)) begin
                            r_start <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_bo <= r_bo + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        r_retry <= 4'd0;
                        if (r_idx == IDX_W'(NUM_REGS - 1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign tbl_idx      = r_idx;
    assign i2c_start    = r_start;
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_reg_data = r_reg_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign retry_cnt    = r_retry;
    assign state_out    = r_state;

endmodule

// File: tb/tb_i2c_reg_seq_init.sv
// Bench for i2c_reg_seq_init: a small I2C controller responder, a transfer scoreboard and directed steps
// covering clean pass, NACK retry, FAIL, timeout, hot-plug re-init and reset mid-transfer.
module tb_i2c_reg_seq_init;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int MR  = 3;
    localparam int BO  = 20;
    localparam int TO  = 100;
    localparam int LAT = 4;

    logic          clk_ref = 1'b0;
    logic          reset;
    logic          go;
    logic          hdmi_tx_int;
    logic [IW-1:0] tbl_idx;
    logic [15:0]   tbl_data;
    logic          i2c_start;
    logic [7:0]    i2c_dev_addr;
    logic [15:0]   i2c_reg_data;
    logic          i2c_ready;
    logic          i2c_ack;
    logic          busy;
    logic          done;
    logic          error;
    logic [3:0]    retry_cnt;
    logic [2:0]    state_out;

    logic [15:0] tbl_mem [NR];
    logic [15:0] exp_q[$];
    int          nack_left [NR];
    logic        always_nack [NR];
    logic        hang = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_idx = -1;
    int          last_cyc = 0;

    assign tbl_data = tbl_mem[tbl_idx];

    i2c_reg_seq_init #(
        .NUM_REGS(NR), .IDX_W(IW), .DEV_ADDR(8'h72), .MAX_RETRY(MR),
        .BACKOFF(BO), .TIMEOUT(TO), .AUTO_START(1)
    ) dut (
        .clk_ref(clk_ref), .reset(reset), .go(go), .hdmi_tx_int(hdmi_tx_int),
        .tbl_idx(tbl_idx), .tbl_data(tbl_data), .i2c_start(i2c_start),
        .i2c_dev_addr(i2c_dev_addr), .i2c_reg_data(i2c_reg_data),
        .i2c_ready(i2c_ready), .i2c_ack(i2c_ack), .busy(busy), .done(done),
        .error(error), .retry_cnt(retry_cnt), .state_out(state_out)
    );

    // clock / cycle counter
    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pass();
        for (int i = 0; i < NR; i++) exp_q.push_back(tbl_mem[i]);
    endtask

    task automatic go_pulse();
        go = 1'b1;
        @(posedge clk_ref); #1;
        go = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state_out !== s && n < budget) begin
            @(posedge clk_ref); #1;
            n++;
        end
        chk(tag, {29'd0, state_out}, {29'd0, s});
    endtask

    task automatic wait_leave(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state_out === s && n < budget) begin
            @(posedge clk_ref); #1;
            n++;
        end
        chk(tag, {31'd0, state_out !== s}, 32'd1);
    endtask

    // controller responder + scoreboard pop on every accepted request
    initial begin
        int idx;
        i2c_ready = 1'b1;
        i2c_ack   = 1'b0;
        forever begin
            @(posedge clk_ref); #1;
            if (!reset && i2c_start === 1'b1 && i2c_ready) begin
                idx = int'(tbl_idx);
                chk("xfer_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) chk("xfer_word", {16'd0, i2c_reg_data}, {16'd0, exp_q.pop_front()});
                chk("xfer_dev_addr", {24'd0, i2c_dev_addr}, 32'h72);
                if (idx == last_idx) chk("backoff_gap", {31'd0, (cyc - last_cyc) >= BO}, 32'd1);
                last_idx  = idx;
                last_cyc  = cyc;
                i2c_ready = 1'b0;
                if (hang) begin
                    while (hang) @(posedge clk_ref);
                    #1;
                    i2c_ack   = 1'b1;
                    i2c_ready = 1'b1;
                end else begin
                    repeat (LAT) @(posedge clk_ref);
                    #1;
                    if (always_nack[idx]) begin
                        i2c_ack = 1'b0;
                    end else if (nack_left[idx] > 0) begin
                        nack_left[idx]--;
                        i2c_ack = 1'b0;
                    end else begin
                        i2c_ack = 1'b1;
                    end
                    i2c_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        int n;
        int max_retry;
        int waits;
        logic [2:0] prev;

        reset       = 1'b1;
        go          = 1'b0;
        hdmi_tx_int = 1'b1;
        for (int i = 0; i < NR; i++) begin
            tbl_mem[i]     = 16'($urandom_range(0, 65535));
            nack_left[i]   = 0;
            always_nack[i] = 1'b0;
        end
        repeat (3) @(posedge clk_ref);
        #1;
        chk("rst_state", {29'd0, state_out}, 32'd0);
        chk("rst_idx", {30'd0, tbl_idx}, 32'd0);
        chk("rst_start", {31'd0, i2c_start}, 32'd0);
        chk("rst_reg_data", {16'd0, i2c_reg_data}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_retry", {28'd0, retry_cnt}, 32'd0);

        // 1: auto start, clean pass
        push_pass();
        reset = 1'b0;
        wait_state(3'd6, 500, "t1_done_state");
        chk("t1_flags", {29'd0, busy, done, error}, 32'b010);
        chk("t1_idx", {30'd0, tbl_idx}, 32'd3);
        chk("t1_q_empty", exp_q.size(), 32'd0);

        // 2: entry 2 NACKed twice
        nack_left[2] = 2;
        exp_q.push_back(tbl_mem[0]);
        exp_q.push_back(tbl_mem[1]);
        repeat (3) exp_q.push_back(tbl_mem[2]);
        exp_q.push_back(tbl_mem[3]);
        go_pulse();
        wait_leave(3'd6, 20, "t2_started");
        max_retry = 0;
        n = 0;
        while (state_out !== 3'd6 && n < 1000) begin
            if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
            @(posedge clk_ref); #1;
            n++;
        end
        chk("t2_done_state", {29'd0, state_out}, 32'd6);
        chk("t2_max_retry", max_retry, 32'd2);
        chk("t2_retry_clr", {28'd0, retry_cnt}, 32'd0);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_q_empty", exp_q.size(), 32'd0);

        // 3: entry 1 always NACKed -> FAIL after MR+1 attempts, go restarts
        always_nack[1] = 1'b1;
        exp_q.push_back(tbl_mem[0]);
        repeat (MR + 1) exp_q.push_back(tbl_mem[1]);
        go_pulse();
        wait_leave(3'd6, 20, "t3_started");
        wait_state(3'd7, 2000, "t3_fail_state");
        chk("t3_flags", {29'd0, busy, done, error}, 32'b001);
        chk("t3_idx", {30'd0, tbl_idx}, 32'd1);
        chk("t3_retry", {28'd0, retry_cnt}, MR);
        chk("t3_q_empty", exp_q.size(), 32'd0);
        always_nack[1] = 1'b0;
        push_pass();
        go_pulse();
        wait_leave(3'd7, 20, "t3_restart");
        chk("t3_restart_idx", {30'd0, tbl_idx}, 32'd0);
        wait_state(3'd6, 500, "t3_done_state");

        // 4: controller hangs -> timeout retries -> FAIL
        hang = 1'b1;
        exp_q.push_back(tbl_mem[0]);
        go_pulse();
        wait_leave(3'd6, 20, "t4_started");
        wait_state(3'd3, 50, "t4_wait_state");
        n = 0;
        while (state_out === 3'd3 && n < 300) begin
            @(posedge clk_ref); #1;
            n++;
        end
        chk("t4_wait_cycles", n, TO);
        waits = 1;
        prev  = state_out;
        n     = 0;
        while (state_out !== 3'd7 && n < 2000) begin
            @(posedge clk_ref); #1;
            if (state_out === 3'd3 && prev !== 3'd3) waits++;
            prev = state_out;
            n++;
        end
        chk("t4_fail_state", {29'd0, state_out}, 32'd7);
        chk("t4_wait_entries", waits, MR + 1);
        chk("t4_error", {31'd0, error}, 32'd1);
        hang = 1'b0;
        repeat (3) @(posedge clk_ref);
        #1;
        push_pass();
        go_pulse();
        wait_leave(3'd7, 20, "t4_restart");
        wait_state(3'd6, 500, "t4_done_state");
        chk("t4_q_empty", exp_q.size(), 32'd0);

        // 5: hot-plug interrupt in DONE
`ifdef HPD_DEBOUNCE_EN
        hdmi_tx_int = 1'b0;
        repeat (10) @(posedge clk_ref);
        #1;
        hdmi_tx_int = 1'b1;
        repeat (5) @(posedge clk_ref);
        #1;
        chk("t5_no_reinit", {29'd0, state_out}, 32'd6);
        push_pass();
        hdmi_tx_int = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 4200) begin
            @(posedge clk_ref); #1;
            n++;
        end
        hdmi_tx_int = 1'b1;
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_debounce_len", {31'd0, n >= 4096}, 32'd1);
`else
        push_pass();
        hdmi_tx_int = 1'b0;
        repeat (10) @(posedge clk_ref);
        #1;
        hdmi_tx_int = 1'b1;
        chk("t5_busy", {31'd0, busy}, 32'd1);
`endif
        wait_state(3'd6, 500, "t5_done_state");
        chk("t5_q_empty", exp_q.size(), 32'd0);

        // 6: reset while waiting on entry 2
        for (int i = 0; i < 3; i++) exp_q.push_back(tbl_mem[i]);
        go_pulse();
        wait_leave(3'd6, 20, "t6_started");
        n = 0;
        while (!(state_out === 3'd3 && tbl_idx === 2'd2) && n < 500) begin
            @(posedge clk_ref); #1;
            n++;
        end
        chk("t6_in_wait_e2", {31'd0, state_out === 3'd3 && tbl_idx === 2'd2}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_state", {29'd0, state_out}, 32'd0);
        chk("t6_idx", {30'd0, tbl_idx}, 32'd0);
        chk("t6_start", {31'd0, i2c_start}, 32'd0);
        chk("t6_reg_data", {16'd0, i2c_reg_data}, 32'd0);
        chk("t6_flags", {29'd0, busy, done, error}, 32'd0);
        chk("t6_retry", {28'd0, retry_cnt}, 32'd0);
        chk("t6_q_empty", exp_q.size(), 32'd0);
        repeat (10) @(posedge clk_ref);
        #1;
        push_pass();
        reset = 1'b0;
        wait_state(3'd6, 500, "t6_done_state");
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_q_final", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
